// File: rtl/gfx_defs.sv
// rtl/gfx_defs.sv - shared graphics types and default video timing
`ifndef GFX_X_RES
`define GFX_X_RES 640
`endif
`ifndef GFX_Y_RES
`define GFX_Y_RES 480
`endif

package gfx_defs;

    typedef logic [29:0] rgb30_t;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
    } vga_timing_t;

    // One FIFO entry: frame markers travel with the pixel they belong to.
    typedef struct packed {
        logic   sop;
        logic   eop;
        rgb30_t data;
    } pix_entry_t;

    // The same struct describes both axes; for the vertical axis the fields count lines.
    localparam vga_timing_t GFX_H_TIMING = '{h_active: `GFX_X_RES, h_fp: 16, h_sync: 96, h_bp: 48};
    localparam vga_timing_t GFX_V_TIMING = '{h_active: `GFX_Y_RES, h_fp: 10, h_sync: 2, h_bp: 33};

    localparam int GFX_VIDEO_FIFO_DEPTH = 16;
    localparam int GFX_VIDEO_CLK_DIV    = 2;

endpackage

// File: rtl/gfx_fifo.sv
// rtl/gfx_fifo.sv - show-ahead synchronous FIFO, power-of-two depth
module gfx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/gfx_video_timing.sv
// rtl/gfx_video_timing.sv - pixel clock divider, h/v counters and sync/active decode
module gfx_video_timing #(
    parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
    parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2,  V_BP = 33,
    parameter int CLK_DIV  = 2,
    parameter int HW = 10, VW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          tick_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          active_o,
    output logic          hsync_n_o,
    output logic          vsync_n_o
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    assign tick_o    = (div_q == DW'(CLK_DIV - 1));
    assign h_o       = h_q;
    assign v_o       = v_q;
    // Compare as int so an end bound equal to 2**HW cannot wrap.
    assign active_o  = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    assign hsync_n_o = !((int'(h_q) >= HS_START) && (int'(h_q) < HS_START + H_SYNC));
    assign vsync_n_o = !((int'(v_q) >= VS_START) && (int'(v_q) < VS_START + V_SYNC));

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (tick_o) begin
            div_d = '0;
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

endmodule

// File: rtl/gfx_video_out.sv
// rtl/gfx_video_out.sv - rgb30 stream sink driving raster video with frame alignment
module gfx_video_out
    import gfx_defs::*;
#(
    parameter int H_ACTIVE   = int'(GFX_H_TIMING.h_active),
    parameter int H_FP       = int'(GFX_H_TIMING.h_fp),
    parameter int H_SYNC     = int'(GFX_H_TIMING.h_sync),
    parameter int H_BP       = int'(GFX_H_TIMING.h_bp),
    parameter int V_ACTIVE   = int'(GFX_V_TIMING.h_active),
    parameter int V_FP       = int'(GFX_V_TIMING.h_fp),
    parameter int V_SYNC     = int'(GFX_V_TIMING.h_sync),
    parameter int V_BP       = int'(GFX_V_TIMING.h_bp),
    parameter int CLK_DIV    = GFX_VIDEO_CLK_DIV,
    parameter int FIFO_DEPTH = GFX_VIDEO_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        scan_ready,
    input  logic        scan_valid,
    input  logic        scan_startofpacket,
    input  logic        scan_endofpacket,
    input  logic [29:0] scan_data,
    output logic [29:0] vga_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        frame_start,
    output logic        underflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic          tick, active, hsync_n, vsync_n;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    gfx_video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .HW(HW), .VW(VW)
    ) u_timing (
        .clk_i(clk), .rst_ni(rst_n), .tick_o(tick), .h_o(h_cnt), .v_o(v_cnt),
        .active_o(active), .hsync_n_o(hsync_n), .vsync_n_o(vsync_n)
    );

    pix_entry_t push_entry, head;
    logic       fifo_full, fifo_empty, push, pop;
    logic       rdy_q;

    // Ready stays low until the first clock after reset release.
    assign scan_ready = rdy_q && !fifo_full;
    assign push       = scan_valid && scan_ready;
    assign push_entry = '{sop: scan_startofpacket, eop: scan_endofpacket, data: scan_data};

    gfx_fifo #(.WIDTH($bits(pix_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .wdata_i(push_entry),
        .full_o(fifo_full), .pop_i(pop), .rdata_o(head), .empty_o(fifo_empty)
    );

    logic [1:0] state_q, state_d;
    rgb30_t     pix_d, data_q;
    logic       fs_d, err;
    logic       hs_q, vs_q, blank_q, fs_q, uf_q;
    logic       at_origin, at_last, run_pix;

    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign at_last   = (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));
    // ARMED joins the running path on the origin tick, so the sop pixel gets the same checks.
    assign run_pix   = tick && active &&
                       ((state_q == ST_RUN) || ((state_q == ST_ARMED) && at_origin));

    always_comb begin
        state_d = (state_q > ST_RUN) ? ST_SEEK : state_q;
        pop     = 1'b0;
        pix_d   = '0;
        fs_d    = 1'b0;
        err     = 1'b0;
        if ((state_q == ST_SEEK) && !fifo_empty) begin
            if (head.sop) state_d = ST_ARMED;
            else          pop     = 1'b1;
        end
        if (run_pix) begin
            state_d = ST_RUN;
            if (fifo_empty || (head.sop && !at_origin)) begin
                err = 1'b1;
            end else begin
                pop = 1'b1;
                if (head.eop != at_last) begin
                    err = 1'b1;
                end else begin
                    pix_d = head.data;
                    fs_d  = at_origin;
                end
            end
            if (err) state_d = ST_SEEK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEEK;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            fs_q    <= tick && fs_d;
            uf_q    <= uf_q || err;
            if (tick) begin
                data_q  <= pix_d;
                hs_q    <= hsync_n;
                vs_q    <= vsync_n;
                blank_q <= active;
            end
        end
    end

    assign vga_data    = data_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_blank_n = blank_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;

endmodule

// File: tb/tb_gfx_video_out.sv
// tb/tb_gfx_video_out.sv - directed bench for gfx_video_out on a 4x2 raster
module tb_gfx_video_out;
    import gfx_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, a_ready, a_valid, a_sop, a_eop, a_hs, a_vs, a_blank, a_fs, a_uf;
    logic [29:0] a_dat, a_data;
    logic        rst_b_n, b_ready, b_valid, b_sop, b_eop, b_hs, b_vs, b_blank, b_fs, b_uf;
    logic [29:0] b_dat, b_data;

    gfx_video_out #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .scan_ready(a_ready), .scan_valid(a_valid),
        .scan_startofpacket(a_sop), .scan_endofpacket(a_eop), .scan_data(a_dat),
        .vga_data(a_data), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_blank_n(a_blank),
        .frame_start(a_fs), .underflow(a_uf)
    );

    gfx_video_out #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .scan_ready(b_ready), .scan_valid(b_valid),
        .scan_startofpacket(b_sop), .scan_endofpacket(b_eop), .scan_data(b_dat),
        .vga_data(b_data), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_blank_n(b_blank),
        .frame_start(b_fs), .underflow(b_uf)
    );

    int checks = 0;
    int errors = 0;

    pix_entry_t  qa[$], qb[$];
    logic [29:0] obs_a[$], obs_b[$], cmp_q[$], exp_q[$];
    int   cyc_a, cyc_b, fs_cnt_a, fs_cnt_b, fs_long_a, fs_long_b;
    int   bad_blank_a, bad_blank_b, acc_cnt_a, acc_cnt_b;
    logic fs_prev_a, fs_prev_b;
    logic hs_b [200];
    logic vs_b [200];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, cmp_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cmp_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), 32'(cmp_q[i]), 32'(exp_q[i]));
    endtask

    task automatic push_frame(input bit to_b, input int base, input int n, input int eop_at);
        pix_entry_t e;
        for (int i = 1; i <= n; i++) begin
            e.sop  = (i == 1);
            e.eop  = (i == eop_at);
            e.data = 30'(base + i);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    task automatic exp_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(30'd0);
    endtask

    task automatic exp_vals(input int base, input int n, input int rep);
        for (int i = 1; i <= n; i++)
            for (int r = 0; r < rep; r++) exp_q.push_back(30'(base + i));
    endtask

    // One clock: present queue heads, retire accepted beats, then record outputs #1 after the edge.
    task automatic step();
        logic acc_a, acc_b;
        a_valid = (qa.size() != 0);
        if (a_valid) begin a_sop = qa[0].sop; a_eop = qa[0].eop; a_dat = qa[0].data; end
        b_valid = (qb.size() != 0);
        if (b_valid) begin b_sop = qb[0].sop; b_eop = qb[0].eop; b_dat = qb[0].data; end
        @(negedge clk);
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (acc_a) begin qa.delete(0); acc_cnt_a++; end
        if (acc_b) begin qb.delete(0); acc_cnt_b++; end
        cyc_a++;
        cyc_b++;
        if (rst_a_n) begin
            if (a_blank) obs_a.push_back(a_data);
            else if (a_data != 30'd0) bad_blank_a++;
            if (a_fs) begin fs_cnt_a++; if (fs_prev_a) fs_long_a++; end
            fs_prev_a = a_fs;
        end
        if (rst_b_n) begin
            if (b_blank) obs_b.push_back(b_data);
            else if (b_data != 30'd0) bad_blank_b++;
            if (b_fs) begin fs_cnt_b++; if (fs_prev_b) fs_long_b++; end
            fs_prev_b = b_fs;
            if (cyc_b < 200) begin hs_b[cyc_b] = b_hs; vs_b[cyc_b] = b_vs; end
        end
    endtask

    task automatic restart(input bit sel);
        if (sel) begin rst_b_n = 1'b0; qb.delete(); end
        else     begin rst_a_n = 1'b0; qa.delete(); end
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        if (sel) begin
            rst_b_n = 1'b1; cyc_b = 0; obs_b.delete(); fs_cnt_b = 0; fs_long_b = 0;
            bad_blank_b = 0; acc_cnt_b = 0; fs_prev_b = 1'b0;
        end else begin
            rst_a_n = 1'b1; cyc_a = 0; obs_a.delete(); fs_cnt_a = 0; fs_long_a = 0;
            bad_blank_a = 0; acc_cnt_a = 0; fs_prev_a = 1'b0;
        end
    endtask

    initial begin
        int lo_h, lo_v;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0; a_dat = '0;
        b_valid = 1'b0; b_sop = 1'b0; b_eop = 1'b0; b_dat = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  32'(a_data),  32'd0);
        chk("rst_hsync", 32'(a_hs),    32'd1);
        chk("rst_vsync", 32'(a_vs),    32'd1);
        chk("rst_blank", 32'(a_blank), 32'd0);
        chk("rst_fs",    32'(a_fs),    32'd0);
        chk("rst_uf",    32'(a_uf),    32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);

        // Nominal: reset frame is black, then two streamed frames back to back.
        restart(1'b0);
        push_frame(1'b0, 0, 8, 8);
        push_frame(1'b0, 8, 8, 8);
        repeat (81) step();
        exp_zeros(8); exp_vals(0, 16, 1);
        cmp_q = obs_a; chk_seq("nominal");
        chk("nom_uf",     32'(a_uf), 32'd0);
        chk("nom_fs_cnt", fs_cnt_a,  32'd2);
        chk("nom_fs_len", fs_long_a, 32'd0);
        chk("nom_blank",  bad_blank_a, 32'd0);

        // Leading junk without sop is discarded.
        restart(1'b0);
        for (int i = 0; i < 3; i++) qa.push_back('{sop: 1'b0, eop: 1'b0, data: 30'(100 + i)});
        push_frame(1'b0, 0, 8, 8);
        repeat (46) step();
        exp_zeros(8); exp_vals(0, 8, 1);
        cmp_q = obs_a; chk_seq("junk");
        chk("junk_uf",     32'(a_uf), 32'd0);
        chk("junk_fs_cnt", fs_cnt_a,  32'd1);

        // Underflow after pixel 5, then recovery on a fresh packet.
        restart(1'b0);
        push_frame(1'b0, 0, 5, 0);
        repeat (43) step();
        chk("uf_before", 32'(a_uf), 32'd0);
        step();
        chk("uf_rise", 32'(a_uf), 32'd1);
        push_frame(1'b0, 10, 8, 8);
        repeat (37) step();
        exp_zeros(8); exp_vals(0, 5, 1); exp_zeros(3); exp_vals(10, 8, 1);
        cmp_q = obs_a; chk_seq("underflow");
        chk("uf_sticky", 32'(a_uf), 32'd1);
        chk("uf_fs_cnt", fs_cnt_a,  32'd2);
        chk("uf_blank",  bad_blank_a, 32'd0);

        // Early eop on pixel 3.
        restart(1'b0);
        push_frame(1'b0, 0, 8, 3);
        push_frame(1'b0, 10, 8, 8);
        repeat (81) step();
        exp_zeros(8); exp_vals(0, 2, 1); exp_zeros(6); exp_vals(10, 8, 1);
        cmp_q = obs_a; chk_seq("early_eop");
        chk("eop_uf",     32'(a_uf), 32'd1);
        chk("eop_fs_cnt", fs_cnt_a,  32'd2);
        rst_a_n = 1'b0;

        // CLK_DIV=2, depth 4: backpressure while ARMED, then the full frame.
        restart(1'b1);
        push_frame(1'b1, 0, 8, 8);
        repeat (20) step();
        chk("bp_accepted", acc_cnt_b,      32'd4);
        chk("bp_ready",    32'(b_ready),   32'd0);
        repeat (73) step();
        exp_zeros(16); exp_vals(0, 8, 2);
        cmp_q = obs_b; chk_seq("div2");
        chk("div2_acc",    acc_cnt_b,  32'd8);
        chk("div2_uf",     32'(b_uf),  32'd0);
        chk("div2_fs_cnt", fs_cnt_b,   32'd1);
        chk("div2_fs_len", fs_long_b,  32'd0);
        chk("div2_blank",  bad_blank_b, 32'd0);

        chk("hs_11", 32'(hs_b[11]), 32'd1);
        chk("hs_12", 32'(hs_b[12]), 32'd0);
        chk("hs_13", 32'(hs_b[13]), 32'd0);
        chk("hs_14", 32'(hs_b[14]), 32'd1);
        chk("vs_43", 32'(vs_b[43]), 32'd1);
        chk("vs_44", 32'(vs_b[44]), 32'd0);
        lo_h = 0; lo_v = 0;
        for (int i = 2; i <= 71; i++) begin
            if (!hs_b[i]) lo_h++;
            if (!vs_b[i]) lo_v++;
        end
        chk("hs_low_cnt", lo_h, 32'd10);
        chk("vs_low_cnt", lo_v, 32'd14);

        // Stream runs dry in the next frame; then reset lands while hsync is low.
        repeat (59) step();
        chk("pre_rst_uf", 32'(b_uf), 32'd1);
        chk("pre_rst_hs", 32'(b_hs), 32'd0);
        rst_b_n = 1'b0;
        #1;
        chk("arst_data",  32'(b_data),  32'd0);
        chk("arst_hsync", 32'(b_hs),    32'd1);
        chk("arst_vsync", 32'(b_vs),    32'd1);
        chk("arst_blank", 32'(b_blank), 32'd0);
        chk("arst_fs",    32'(b_fs),    32'd0);
        chk("arst_uf",    32'(b_uf),    32'd0);
        chk("arst_ready", 32'(b_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
